// File: rtl/io_fifo_responder.sv
// Two-word bus responder: DATA reads the synchronized switches and pushes LED words into a FIFO; CTRL/STAT sets the drain period and reports status.
// Optional feature macro: IO_FIFO_RESP_OVF_STICKY_EN adds a sticky overflow flag that a CTRL write with bit 15 set clears.
module io_fifo_responder #(
   parameter logic [15:0] BASE       = 16'h2000,
   parameter int          DEPTH      = 4,
   parameter logic [15:0] RST_PERIOD = 16'd8
) (
   input  logic        clock,
   input  logic        reset_L,
   input  logic [15:0] memAddr,
   inout  wire  [15:0] dataBus,
   input  logic        re_L,
   input  logic        we_L,
   input  logic [15:0] SW,
   output logic [15:0] LEDR_
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [15:0]   r_sw_meta;
   logic [15:0]   r_sw_sync;
   logic [15:0]   r_sw_prev;
   logic          r_chg;
   logic [15:0]   r_mem [DEPTH];
   logic [AW-1:0] r_head;
   logic [AW-1:0] r_tail;
   logic [CW-1:0] r_count;
   logic [15:0]   r_drain;
   logic [15:0]   r_period;

   logic          w_sel_data;
   logic          w_sel_ctrl;
   logic          w_rd_en;
   logic          w_data_rd;
   logic          w_wr_data;
   logic          w_wr_ctrl;
   logic          w_empty;
   logic          w_full;
   logic          w_pop;
   logic          w_push;
   logic          w_sw_change;
   logic          w_ovf;
   logic [15:0]   w_period_raw;
   logic [15:0]   w_new_period;
   logic [3:0]    w_count4;
   logic [15:0]   w_stat;
   logic [15:0]   w_rd_val;

   assign w_sel_data  = (memAddr == BASE);
   assign w_sel_ctrl  = (memAddr == BASE + 16'd1);
   // The bus is only driven outside reset and never while a writer owns it.
   assign w_rd_en     = reset_L && !re_L && we_L && (w_sel_data || w_sel_ctrl);
   assign w_data_rd   = !re_L && w_sel_data;
   assign w_wr_data   = reset_L && !we_L && w_sel_data;
   assign w_wr_ctrl   = reset_L && !we_L && w_sel_ctrl;

   assign w_empty     = (r_count == '0);
   assign w_full      = (r_count == FULL_CNT);
   assign w_pop       = !w_empty && (r_drain == r_period - 16'd1);
   assign w_push      = w_wr_data && (!w_full || w_pop);
   assign w_sw_change = (r_sw_sync != r_sw_prev);

`ifdef IO_FIFO_RESP_OVF_STICKY_EN
   logic r_ovf;
   logic w_drop;
   assign w_drop       = w_wr_data && w_full && !w_pop;
   assign w_ovf        = r_ovf;
   assign w_period_raw = {1'b0, dataBus[14:0]};
`else
   assign w_ovf        = 1'b0;
   assign w_period_raw = dataBus;
`endif

   assign w_new_period = (w_period_raw == 16'd0) ? 16'd1 : w_period_raw;
   assign w_count4     = 4'(r_count);
   assign w_stat       = {8'h00, w_count4, w_ovf, r_chg, w_empty, w_full};
   assign w_rd_val     = w_sel_data ? r_sw_sync : w_stat;
   assign dataBus      = w_rd_en ? w_rd_val : 16'hzzzz;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock) begin
      if (!reset_L) begin
         r_sw_meta <= '0;
         r_sw_sync <= '0;
         r_sw_prev <= '0;
         r_chg     <= 1'b0;
         r_head    <= '0;
         r_tail    <= '0;
         r_count   <= '0;
         r_drain   <= '0;
         r_period  <= RST_PERIOD;
         LEDR_     <= 16'h0000;
      end else begin
         r_sw_meta <= SW;
         r_sw_sync <= r_sw_meta;
         r_sw_prev <= r_sw_sync;

         if (w_sw_change)    r_chg <= 1'b1;
         else if (w_data_rd) r_chg <= 1'b0;

         if (w_wr_ctrl) r_period <= w_new_period;

         if (w_push) r_tail <= r_tail + AW'(1);
         if (w_pop) begin
            r_head <= r_head + AW'(1);
            LEDR_  <= r_mem[r_head];
         end

         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase

         // A shortened period can leave the counter past the new terminal value.
         if (w_empty || w_pop || (r_drain > r_period - 16'd1)) r_drain <= '0;
         else                                                   r_drain <= r_drain + 16'd1;
      end
   end

`ifdef IO_FIFO_RESP_OVF_STICKY_EN
   always_ff @(posedge clock) begin
      if (!reset_L)                     r_ovf <= 1'b0;
      else if (w_drop)                  r_ovf <= 1'b1;
      else if (w_wr_ctrl && dataBus[15]) r_ovf <= 1'b0;
   end
`endif

   // NOTE: FIFO storage has no reset; the pointers and count alone decide which entries are valid.
   always_ff @(posedge clock) begin
      if (w_push) r_mem[r_tail] <= dataBus;
   end

endmodule

// File: doc/io_fifo_responder.md
IO_FIFO_RESPONDER -- requirements
Module: io_fifo_responder

Interface
REQ-001 Parameter BASE, default 16'h2000: base address of the 2-word responder window.
REQ-002 Parameter DEPTH, default 4: LED FIFO depth in words; power of two, range 2..16.
REQ-003 Parameter RST_PERIOD, default 16'd8: reset value of the drain period register.
REQ-004 Port clock  input  1: single clock; all state updates on the rising edge.
REQ-005 Port reset_L  input  1: reset is synchronous and active-low.
REQ-006 Port memAddr  input  16: bus address from the MAR.
REQ-007 Port dataBus  inout  16: shared memory data bus.
REQ-008 Port re_L  input  1: bus read strobe, active-low.
REQ-009 Port we_L  input  1: bus write strobe, active-low.
REQ-010 Port SW  input  16: asynchronous switch inputs.
REQ-011 Port LEDR_  output  16: registered LED output word.

Function
REQ-012 Address map: BASE+0 is DATA; BASE+1 is CTRL/STAT; all other addresses are ignored and dataBus stays Z.
REQ-013 Read: while re_L=0 and memAddr is in the window, dataBus is driven combinationally; otherwise it is Z; the block never drives while we_L=0.
REQ-014 DATA read returns sw_sync, the 2-flop synchronized SW value.
REQ-015 STAT read returns {8'b0, count[3:0], ovf, chg, empty, full}: bit0 full, bit1 empty, bit2 chg, bit3 ovf (0 when REQ-033 is disabled), bits[7:4] FIFO occupancy.
REQ-016 Write: sampled on the clock edge where we_L=0 and the address matches, taking dataBus as the value.
REQ-017 DATA write pushes dataBus into the FIFO tail when the FIFO is not full.
REQ-018 DATA write while the FIFO is full and no pop occurs in the same cycle: the word is dropped and the FIFO is unchanged.
REQ-019 CTRL write loads period from dataBus; a value of 0 is treated as 1.
REQ-020 chg is set on the cycle sw_sync differs from its previous registered value.
REQ-021 chg is cleared by the cycle end of a DATA read (re_L=0 at BASE+0); if a new change occurs in the same cycle, set wins.
REQ-022 Drain counter: reset to 0 while the FIFO is empty; otherwise it increments each cycle.
REQ-023 When the drain counter reaches period-1, the head is popped into LEDR_ on that edge and the counter returns to 0.
REQ-024 First pop occurs exactly max(period,1) cycles after the FIFO becomes non-empty.
REQ-025 Push and pop in the same cycle: both happen and occupancy is unchanged. This applies when full, so a write to a full FIFO is accepted if a pop coincides.
REQ-026 Push into an empty FIFO: the word becomes visible at the head on the next cycle and is never popped in the same cycle it is pushed.
REQ-027 Head and tail pointers wrap modulo DEPTH.
REQ-028 occupancy is kept with one extra bit so that full (count==DEPTH) and empty (count==0) are distinct.
REQ-029 A period change mid-drain takes effect at the next counter comparison and does not reset the counter. If the counter already exceeds the new period-1, it is forced to 0 on the next edge.

Reset
REQ-030 On a clock edge with reset_L=0, regardless of any bus activity, the following are cleared: FIFO pointers and count, drain counter, LEDR_=16'h0000, chg=0, ovf=0, period=RST_PERIOD, and synchronizer flops=0.
REQ-031 dataBus is Z during reset, and writes are ignored in the reset cycle.
REQ-032 Reset mid-drain discards all queued words, and no pop occurs on the reset edge.

Configuration
REQ-033 Macro IO_FIFO_RESP_OVF_STICKY_EN: when defined, ovf is set by any write dropped per REQ-018 and cleared only by a CTRL write with dataBus[15]=1, which writes period from dataBus[14:0]; when not defined, ovf logic is absent, STAT bit3 reads 0, and CTRL writes use all 16 bits as period.

Verification
REQ-034 Reset, then STAT read -> 16'h0002 (empty), LEDR_=0, dataBus Z outside reads.
REQ-035 Write 16'hBEEF to 2000, period 8 -> LEDR_=16'hBEEF exactly 8 cycles after the FIFO goes non-empty; STAT returns 16'h0002 afterward.
REQ-036 Period 16'hFFFF, write 5 words (1..5) -> STAT 16'h0041 (count 4, full); word 5 dropped; with macro defined, STAT 16'h0049 and ovf stays set until a CTRL write of 16'h8003.
REQ-037 FIFO full, period 1, and a write coinciding with a pop -> the word is accepted, count stays 4, and LEDR_ sequence is preserved in order through a pointer wrap.
REQ-038 SW changes to 16'h00A5 -> chg=1 two to three cycles later; DATA read returns 16'h00A5 and clears chg; a read at 16'h2002 leaves dataBus Z.
REQ-039 reset_L=0 for one cycle with 3 words queued -> next cycle count=0, LEDR_=0, period=RST_PERIOD, and no pop.
